// File: rtl/ascon_duplex_engine.sv
// Iterative Ascon-style duplex AEAD engine. One permutation round runs per clock.
// Encrypt and decrypt stream blocks over valid/ready handshakes and finish with a tag.
module ascon_duplex_engine #(
    parameter int DATA_W   = 128,
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] nonce,
    input  logic [DATA_W-1:0] tag_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] tag_out,
    output logic              tag_valid,
    output logic              tag_ok,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, INIT, ABSORB, OUT, PERM_B, FINAL, DONE} state_t;

    localparam logic [3:0] RA = 4'(ROUNDS_A);
    localparam logic [3:0] RB = 4'(ROUNDS_B);

    state_t            state;
    logic [DATA_W-1:0] s, key_q, tag_in_q, s_rnd, tag_next;
    logic [3:0]        cnt, rounds, j;
    logic [7:0]        rc;
    logic              mode_q, last_q, last_round;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] round_fn(input logic [DATA_W-1:0] x, input logic [7:0] c);
        logic [DATA_W-1:0] t;
        t = x ^ {(DATA_W/8){c}};
        return t ^ rotr(t, 19) ^ rotr(t, 28) ^ (rotr(t, 1) & rotr(t, 2));
    endfunction

    // Round index is offset so the final round of every phase lands on j=11.
    always_comb begin
        rounds     = (state == PERM_B) ? RB : RA;
        j          = 4'd12 - rounds + cnt;
        rc         = {~j, j};
        last_round = (cnt == rounds - 4'd1);
        s_rnd      = round_fn(s, rc);
        tag_next   = s_rnd ^ key_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '0;
            cnt       <= '0;
            key_q     <= '0;
            tag_in_q  <= '0;
            mode_q    <= 1'b0;
            last_q    <= 1'b0;
            out_data  <= '0;
            tag_out   <= '0;
            tag_ok    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            tag_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mode_q   <= mode;
                    key_q    <= key;
                    tag_in_q <= tag_in;
                    s        <= key ^ nonce;
                    cnt      <= '0;
                    tag_out  <= '0;
                    tag_ok   <= 1'b0;
                    busy     <= 1'b1;
                    state    <= INIT;
                end
                INIT: begin
                    if (last_round) begin
                        s        <= s_rnd ^ key_q;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        state    <= ABSORB;
                    end else begin
                        s   <= s_rnd;
                        cnt <= cnt + 4'd1;
                    end
                end
                ABSORB: if (in_valid) begin
                    out_data  <= s ^ in_data;
                    // Duplex state always carries the ciphertext, whichever direction.
                    s         <= mode_q ? in_data : (s ^ in_data);
                    last_q    <= in_last;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last_q) begin
                        s     <= s ^ key_q;
                        state <= FINAL;
                    end else begin
                        state <= PERM_B;
                    end
                end
                PERM_B: begin
                    s <= s_rnd;
                    if (last_round) begin
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        state    <= ABSORB;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FINAL: begin
                    s <= s_rnd;
                    if (last_round) begin
                        cnt       <= '0;
                        tag_out   <= tag_next;
                        tag_ok    <= mode_q && (tag_next == tag_in_q);
                        tag_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_duplex_engine.sv
// Randomized scoreboard bench for ascon_duplex_engine: a 128/12/6 instance and a 64/1/1 instance,
// both checked against a message-level duplex model built from bitwise rotation indexing.
module tb_ascon_duplex_engine;
    localparam int W  = 128;
    localparam int RA = 12;
    localparam int RB = 6;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] N0 = 128'h101112131415161718191a1b1c1d1e1f;

    typedef logic [127:0] q_t[$];
    typedef struct {
        logic [127:0] tag;
        logic         ok;
    } tag_exp_t;

    logic         clk = 1'b0;
    logic         rst_n, start, mode, in_valid, in_last, out_ready;
    logic [W-1:0] key, nonce, tag_in, in_data;
    logic         in_ready, out_valid, tag_valid, tag_ok, busy;
    logic [W-1:0] out_data, tag_out;

    logic         s_start, s_mode, s_in_valid, s_in_last, s_out_ready;
    logic [63:0]  s_key, s_nonce, s_tag_in, s_in_data;
    logic         s_in_ready, s_out_valid, s_tag_valid, s_tag_ok, s_busy;
    logic [63:0]  s_out_data, s_tag_out;

    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    q_t       exp_q, s_exp_q;
    tag_exp_t tag_q[$];
    tag_exp_t s_tag_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_duplex_engine #(.DATA_W(W), .ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key), .nonce(nonce),
        .tag_in(tag_in), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tag_out(tag_out), .tag_valid(tag_valid), .tag_ok(tag_ok), .busy(busy)
    );

    ascon_duplex_engine #(.DATA_W(64), .ROUNDS_A(1), .ROUNDS_B(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .key(s_key), .nonce(s_nonce),
        .tag_in(s_tag_in), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .tag_out(s_tag_out), .tag_valid(s_tag_valid), .tag_ok(s_tag_ok), .busy(s_busy)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: bit i of rotr(t,n) is t[(i+n) mod w]; byte-replicated constant bit i is rc[i mod 8].
    function automatic logic [127:0] m_round(input logic [127:0] x, input int w, input int jr);
        logic [3:0]   jj;
        logic [7:0]   rcm;
        logic [127:0] t, r;
        jj  = 4'(jr);
        rcm = {~jj, jj};
        t   = '0;
        r   = '0;
        for (int i = 0; i < w; i++) t[i] = x[i] ^ rcm[i % 8];
        for (int i = 0; i < w; i++)
            r[i] = t[i] ^ t[(i + 19) % w] ^ t[(i + 28) % w] ^ (t[(i + 1) % w] & t[(i + 2) % w]);
        return r;
    endfunction

    function automatic logic [127:0] m_perm(input logic [127:0] x, input int w, input int nr);
        logic [127:0] v;
        v = x;
        for (int r = 0; r < nr; r++) v = m_round(v, w, 12 - nr + r);
        return v;
    endfunction

    task automatic m_aead(input bit dec, input logic [127:0] k, input logic [127:0] n, input int w,
                          input int ra, input int rb, input q_t blk, output q_t outs, output logic [127:0] tag);
        logic [127:0] st, o;
        outs = {};
        st = m_perm(k ^ n, w, ra) ^ k;
        foreach (blk[i]) begin
            if (i > 0) st = m_perm(st, w, rb);
            o = st ^ blk[i];
            outs.push_back(o);
            st = dec ? blk[i] : o;
        end
        tag = m_perm(st ^ k, w, ra) ^ k;
    endtask

    task automatic wait_ready(output int at);
        at = -1;
        for (int i = 0; i < 200 && at < 0; i++) begin
            if (in_ready) at = cyc;
            else @(negedge clk);
        end
        if (at < 0) timeout("in_ready_wait");
    endtask

    task automatic wait_hs(output int at);
        at = -1;
        for (int i = 0; i < 200 && at < 0; i++) begin
            if (out_valid && out_ready) at = cyc;
            else @(negedge clk);
        end
        if (at < 0) timeout("out_handshake_wait");
    endtask

    task automatic wait_idle();
        int seen;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            if (!busy) seen = 1;
            else @(negedge clk);
        end
        if (seen == 0) timeout("idle_wait");
    endtask

    task automatic run_msg(input bit dec, input logic [127:0] k, input logic [127:0] n, input logic [127:0] ti,
                           input q_t blk, input q_t exp_out, input logic [127:0] exp_tag, input bit exp_ok,
                           input int bp_blk, input bit perturb, input bit abort);
        int t0, at, c, nb;
        tag_exp_t te;
        nb = blk.size();
        c  = 0;
        @(negedge clk);
        mode = dec; key = k; nonce = n; tag_in = ti; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        if (perturb) begin
            key = ~k; nonce = ~n; tag_in = ~ti; mode = ~dec;
            in_valid = 1'b1; in_last = 1'b1; in_data = rnd128();
            repeat (4) @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
        end
        for (int i = 0; i < nb; i++) begin
            wait_ready(at);
            if (at < 0) return;
            if (i == 0) check("in_ready_first", 128'(at), 128'(t0 + RA + 1));
            else        check("in_ready_next", 128'(at), 128'(c + RB + 1));
            if (perturb && i == 0) begin
                start = 1'b1; key = rnd128(); nonce = rnd128();
                @(negedge clk);
                start = 1'b0;
            end
            exp_q.push_back(exp_out[i]);
            if (i == nb - 1) begin
                te.tag = exp_tag;
                te.ok  = exp_ok;
                tag_q.push_back(te);
            end
            in_valid = 1'b1; in_data = blk[i]; in_last = (i == nb - 1);
            if (i == bp_blk) out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; in_data = rnd128();
            if (i == bp_blk) begin
                repeat (5) begin
                    check("bp_out_valid", 128'(out_valid), 128'(1));
                    check("bp_in_ready", 128'(in_ready), 128'(0));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            wait_hs(c);
            if (c < 0) return;
            if (abort) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("abort_busy", 128'(busy), 128'(0));
                check("abort_in_ready", 128'(in_ready), 128'(0));
                check("abort_out_valid", 128'(out_valid), 128'(0));
                check("abort_tag_valid", 128'(tag_valid), 128'(0));
                check("abort_out_data", out_data, 128'(0));
                check("abort_tag_out", tag_out, 128'(0));
                check("abort_pending_out", 128'(exp_q.size()), 128'(0));
                return;
            end
        end
        wait_idle();
        check("tag_consumed", 128'(tag_q.size()), 128'(0));
    endtask

    task automatic run_small(input logic [63:0] k, input logic [63:0] n, input q_t blk);
        q_t           outs;
        logic [127:0] tag;
        tag_exp_t     te;
        int           t0, at, c, nb;
        nb = blk.size();
        c  = 0;
        m_aead(1'b0, {64'b0, k}, {64'b0, n}, 64, 1, 1, blk, outs, tag);
        @(negedge clk);
        s_key = k; s_nonce = n; s_start = 1'b1; t0 = cyc;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            at = -1;
            for (int w = 0; w < 50 && at < 0; w++) begin
                if (s_in_ready) at = cyc;
                else @(negedge clk);
            end
            if (at < 0) begin timeout("s_in_ready_wait"); return; end
            if (i == 0) check("s_in_ready_first", 128'(at), 128'(t0 + 2));
            else        check("s_in_ready_next", 128'(at), 128'(c + 2));
            s_exp_q.push_back(outs[i]);
            if (i == nb - 1) begin
                te.tag = tag;
                te.ok  = 1'b0;
                s_tag_q.push_back(te);
            end
            s_in_valid = 1'b1; s_in_data = blk[i][63:0]; s_in_last = (i == nb - 1);
            @(negedge clk);
            s_in_valid = 1'b0; s_in_last = 1'b0;
            c = -1;
            for (int w = 0; w < 50 && c < 0; w++) begin
                if (s_out_valid && s_out_ready) c = cyc;
                else @(negedge clk);
            end
            if (c < 0) begin timeout("s_handshake_wait"); return; end
        end
        at = -1;
        for (int w = 0; w < 50 && at < 0; w++) begin
            if (!s_busy) at = cyc;
            else @(negedge clk);
        end
        if (at < 0) timeout("s_idle_wait");
        check("s_tag_consumed", 128'(s_tag_q.size()), 128'(0));
    endtask

    // Main-instance monitor: pops expectations on handshakes/tag pulses and polices OUT-state holding.
    int           m_last_hs = 0;
    logic         m_pend = 1'b0;
    logic [127:0] m_pdata = '0;
    tag_exp_t     m_te;
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (m_pend) begin
                check("hold_out_valid", 128'(out_valid), 128'(1));
                check("hold_out_data", out_data, m_pdata);
                check("hold_in_ready", 128'(in_ready), 128'(0));
            end
            if (out_valid && out_ready) begin
                m_last_hs = cyc;
                if (exp_q.size() == 0) timeout("out_unexpected");
                else check("out_data", out_data, exp_q.pop_front());
            end
            if (tag_valid) begin
                if (tag_q.size() == 0) timeout("tag_unexpected");
                else begin
                    m_te = tag_q.pop_front();
                    check("tag_out", tag_out, m_te.tag);
                    check("tag_ok", 128'(tag_ok), 128'(m_te.ok));
                    check("tag_latency", 128'(cyc), 128'(m_last_hs + RA + 1));
                end
            end
        end
        m_pend  = rst_n && out_valid && !out_ready;
        m_pdata = out_data;
    end

    int       s_last_hs = 0;
    tag_exp_t s_te;
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (s_out_valid && s_out_ready) begin
                s_last_hs = cyc;
                if (s_exp_q.size() == 0) timeout("s_out_unexpected");
                else check("s_out_data", {64'b0, s_out_data}, s_exp_q.pop_front());
            end
            if (s_tag_valid) begin
                if (s_tag_q.size() == 0) timeout("s_tag_unexpected");
                else begin
                    s_te = s_tag_q.pop_front();
                    check("s_tag_out", {64'b0, s_tag_out}, s_te.tag);
                    check("s_tag_ok", 128'(s_tag_ok), 128'(s_te.ok));
                    check("s_tag_latency", 128'(cyc), 128'(s_last_hs + 2));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        q_t           pt, ct, outs, z;
        logic [127:0] tag, rtag, ti, k, n;
        bit           dec;
        int           nb, bp;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        key = '0; nonce = '0; tag_in = '0; in_data = '0;
        s_start = 1'b0; s_mode = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b1;
        s_key = '0; s_nonce = '0; s_tag_in = '0; s_in_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_tag_valid", 128'(tag_valid), 128'(0));
        check("rst_tag_ok", 128'(tag_ok), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_tag_out", tag_out, 128'(0));

        pt = {};
        repeat (3) pt.push_back(rnd128());
        m_aead(1'b0, K0, N0, W, RA, RB, pt, ct, tag);
        run_msg(1'b0, K0, N0, rnd128(), pt, ct, tag, 1'b0, -1, 1'b0, 1'b0);
        run_msg(1'b1, K0, N0, tag, ct, pt, tag, 1'b1, -1, 1'b0, 1'b0);
        run_msg(1'b1, K0, N0, tag ^ 128'd1, ct, pt, tag, 1'b0, -1, 1'b0, 1'b0);
        run_msg(1'b0, K0, N0, '0, pt, ct, tag, 1'b0, 1, 1'b0, 1'b0);
        run_msg(1'b0, K0, N0, '0, pt, ct, tag, 1'b0, -1, 1'b1, 1'b0);

        for (int m = 0; m < 5; m++) begin
            k   = rnd128();
            n   = rnd128();
            dec = 1'($urandom_range(0, 1));
            nb  = int'($urandom_range(1, 4));
            bp  = int'($urandom_range(0, 4));
            pt  = {};
            for (int b = 0; b < nb; b++) pt.push_back(rnd128());
            m_aead(dec, k, n, W, RA, RB, pt, outs, rtag);
            ti = ($urandom_range(0, 1) == 1) ? rtag : rnd128();
            run_msg(dec, k, n, ti, pt, outs, rtag, dec && (ti == rtag), bp, 1'b0, 1'b0);
        end

        pt = {};
        repeat (3) pt.push_back(rnd128());
        m_aead(1'b0, K0, N0, W, RA, RB, pt, ct, tag);
        run_msg(1'b0, K0, N0, '0, pt, ct, tag, 1'b0, -1, 1'b0, 1'b1);
        run_msg(1'b0, K0, N0, '0, pt, ct, tag, 1'b0, -1, 1'b0, 1'b0);

        z = {};
        z.push_back('0);
        run_small(64'd0, 64'd0, z);
        z = {};
        repeat (2) z.push_back({64'b0, $urandom(), $urandom()});
        run_small({$urandom(), $urandom()}, {$urandom(), $urandom()}, z);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ascon_duplex_engine.md
Name: ascon_duplex_engine

Overview:
- Parametrised, streaming successor to the single-shot 128-bit encrypt block.
- Iterative Ascon-style duplex AEAD engine (one permutation round per clock) supporting encrypt and decrypt of multi-block messages.
- Valid/ready handshakes on input and output; emits a tag and, in decrypt mode, a tag-match flag.
- Sits between the host data mover and the key/nonce register bank.

Parameters:
DATA_W, 128, state/block/key/nonce/tag width; multiple of 64, ≥64
ROUNDS_A, 12, rounds for init and finalisation permutations; 1..12
ROUNDS_B, 6, rounds between message blocks; 1..12

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
mode  in  1  0=encrypt, 1=decrypt; latched at start
key  in  DATA_W  latched at start
nonce  in  DATA_W  latched at start
tag_in  in  DATA_W  expected tag (decrypt); latched at start
in_valid  in  1  input block valid
in_ready  out  1  engine accepts block
in_data  in  DATA_W  plaintext (enc) / ciphertext (dec)
in_last  in  1  final block of message
out_valid  out  1  output block valid
out_ready  in  1  consumer accepts block
out_data  out  DATA_W  ciphertext (enc) / plaintext (dec)
tag_out  out  DATA_W  computed tag
tag_valid  out  1  one-cycle pulse when tag_out/tag_ok are final
tag_ok  out  1  decrypt: tag_out==tag_in; encrypt: 0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state→IDLE; S, round counter, out_data, tag_out cleared to 0; all 1-bit outputs 0. Applies mid-operation; the in-flight message is abandoned.
- Round r of an R-round permutation uses j=12-R+r and rc={~j[3:0],j[3:0]}, giving 8'hF0 for j=0 through 8'h4B for j=11.
- Round function: t=S^{DATA_W/8{rc}}; S'=t^rotr(t,19)^rotr(t,28)^(rotr(t,1)&rotr(t,2)). Rotations are over the full DATA_W.

FSM:
- IDLE: in_ready=0. On start, latch mode/key/nonce/tag_in, load S=key^nonce, go INIT.
- INIT: ROUNDS_A cycles, one round each. On the last round, write S=P(S)^key. Go ABSORB.
- ABSORB: in_ready=1.
  - On in_valid&&in_ready: out_data=S^in_data.
  - S becomes the ciphertext (in_data if decrypt, S^in_data if encrypt).
  - Latch in_last. Go OUT.
- OUT: out_valid=1, in_ready=0; out_data held stable until out_ready.
  - On handshake, if last: S=S^key, go FINAL.
  - Otherwise go PERM_B.
- PERM_B: ROUNDS_B rounds, then ABSORB.
- FINAL: ROUNDS_A rounds. On the last round, tag_out=P(S)^key; tag_ok=(mode && tag_out==tag_in). Go DONE.
- DONE: tag_valid=1 for one cycle, then IDLE. tag_out and tag_ok hold until next start or reset.

Latency (start accepted at cycle t, out handshake at cycle c):
- in_ready first high at t+ROUNDS_A+1.
- Next in_ready after a non-last block at c+ROUNDS_B+1.
- tag_valid at c+ROUNDS_A+1.

Boundary rules:
- start outside IDLE is ignored; key/nonce/tag_in changes while busy have no effect.
- in_valid outside ABSORB is ignored; no data is consumed.
- Minimum message is one block; zero-length messages are unsupported.
- Decrypt streams plaintext before tag check; the consumer discards it if tag_ok=0.
- out_valid must not drop before handshake.
- Round counter width is 4 bits; it wraps to 0 at each phase end.

Test Plan:
- Reset: hold rst_n=0 2 cycles mid-PERM_B → next cycle busy=0, in_ready=0, out_valid=0, tag_valid=0, out_data=0, tag_out=0.
- Encrypt, DATA_W=128/12/6: key=128'h000102…0F, nonce=128'h101112…1F, 3 blocks, out_ready=1 → in_ready at t+13, t+c+7 spacing, tag_valid at c_last+13; out_data/tag_out match bench C model bit-exact.
- Decrypt: feed the ciphertext/tag from the encrypt test → out_data equals original plaintext, tag_ok=1. Repeat with tag_in bit 0 flipped → same plaintext and tag_out, tag_ok=0.
- Backpressure: out_ready=0 for 5 cycles in OUT → out_valid=1 and out_data constant, in_ready=0; completes correctly after release.
- Ignored events: start pulsed with a different key during ABSORB, and in_valid during INIT → results identical to the unperturbed run.
- Parameter sweep: DATA_W=64, ROUNDS_A=1, ROUNDS_B=1, key=nonce=0, single block of 0 → S before absorb follows round rule with rc=8'h4B; out_data matches model; tag_valid at c+2.
